proc_mem_responder: RTL and testbench
=====================================

Name: proc_mem_responder

Overview:
- Memory-side responder for the processor's request/response memory interface: accepts read/write requests and returns responses after a fixed pipeline latency.
- Adds val/rdy flow control on both the request and response sides.
- Serves as a multi-cycle data-memory model for latency-tolerant processor variants and for bench-driven memory traffic.
- Backed by a word-addressed storage array, a fixed-latency delay pipeline and a response queue with credit-based admission.

Parameters:
- NUM_WORDS, 256: storage depth in 32-bit words; power of two.
- LATENCY, 2: accept-to-response delay in cycles; legal range 1..4.
- QDEPTH, 4: response queue entries; power of two, >= 2.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- req_val  input  1  request valid.
- req_rdy  output  1  responder can accept a request.
- req_type  input  1  request type: 0 = read, 1 = write.
- req_addr  input  32  byte address.
- req_wdata  input  32  write data.
- resp_val  output  1  response valid.
- resp_rdy  input  1  consumer accepts the response.
- resp_type  output  1  echoes req_type.
- resp_data  output  32  read data; 0 for writes and for errors.
- resp_err  output  1  request was misaligned or out of range.

Behaviour:
- Accept and dequeue:
  - A request is accepted on a rising edge with req_val && req_rdy.
  - A response is dequeued on a rising edge with resp_val && resp_rdy.
- Address decode:
  - Word index = req_addr[log2(NUM_WORDS)+1:2].
  - err = (req_addr[1:0] != 0) || (req_addr >= 4*NUM_WORDS).
- Storage access happens on the accept edge:
  - A write commits at that edge; an erroneous write is dropped, with no aliasing.
  - A read samples the array at that edge, so it observes all writes accepted on earlier edges.
  - A read in the same cycle as a write cannot occur (one request per cycle).
- Delay pipeline:
  - LATENCY stages, each holding {valid, type, data, err}.
  - Stage 0 is loaded on the accept edge; entries advance every edge unconditionally (the pipeline never stalls).
  - The last stage enqueues into the response queue.
- Latency: a request accepted at edge E, with the queue empty, shows resp_val=1 in the cycle after edge E+LATENCY.
- Throughput: 1 request/cycle while resp_rdy=1.
- Credit counter:
  - Width log2(QDEPTH)+1; reset value QDEPTH.
  - Decrements on accept and increments on dequeue; unchanged when both occur in the same edge.
  - Invariant: credits = QDEPTH - (pipeline valids + queue occupancy). Queue overflow is therefore impossible.
- req_rdy = (credits != 0) && rst deasserted.
- Response outputs:
  - resp_val = queue not empty.
  - resp_type, resp_data and resp_err come from the queue head and hold stable while resp_val && !resp_rdy.
- Ordering: responses are returned strictly in accept order.
- Queue full with dequeue: entering from the pipeline while the queue is full with a simultaneous dequeue is legal (pointer wrap). The credit scheme guarantees a slot exists.
- Reset (any time, including mid-operation):
  - Clears pipeline valids, queue pointers and occupancy; sets credits to QDEPTH.
  - While rst is low: req_rdy=0, resp_val=0, resp_data=0, resp_type=0, resp_err=0.
  - In-flight requests are discarded.
  - Storage contents are not reset.
- Ignored inputs: req_* while req_rdy=0, and resp_rdy while resp_val=0.

Decomposition:
- Package proc_mem_pkg:
  - Request-type constants MEM_READ=0 and MEM_WRITE=1.
  - Response struct {type, data[31:0], err}.
  - Address-decode helper.
- Sub-module proc_mem_resp_queue: parameterised synchronous FIFO of response structs with enq/deq, full/empty and wrap-safe pointers.
- The storage array, delay pipeline and credit logic stay in proc_mem_responder.

Test Plan:
1. Reset: rst=0 for 3 cycles -> req_rdy=0 and resp_val=0. Release -> req_rdy=1 on the next cycle; credits internally = 4.
2. Back-to-back write then read, resp_rdy=1 (LATENCY=2): write 0xDEADBEEF to 0x10 at edge E0, then read 0x10 at E0+1 -> response {type 1, data 0, err 0} after E0+2, then {type 0, data 0xDEADBEEF, err 0} after E0+3.
3. Backpressure: resp_rdy=0, stream 6 reads -> exactly 4 accepted, then req_rdy=0 and held. Set resp_rdy=1 -> 4 responses in order, data stable during the stall; req_rdy=1 in the cycle after the first dequeue.
4. Errors (NUM_WORDS=256): read 0x402 and read 0x400 -> both err=1, data 0. Write 0x11111111 to 0x400, then read 0x0 -> previous value of 0x0, err=0.
5. Reset mid-flight: 3 reads accepted, assert rst before any response -> resp_val=0 immediately. After release: no stale responses appear within 10 cycles and 4 requests are accepted back to back.
6. Simultaneous accept/dequeue at credits=1: accept and dequeue on the same edge -> credits stay 1, req_rdy remains 1, and the following response order is preserved.

Source files
------------

// File: rtl/proc_mem_pkg.sv
// Shared types and helpers for the request/response memory responder.
// Holds request-type constants, the response record and address decode.
package proc_mem_pkg;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    typedef struct packed {
        logic        typ;
        logic [31:0] data;
        logic        err;
    } mem_resp_t;

    function automatic logic addr_err(
        input logic [31:0] addr,
        input int unsigned num_words
    );
        logic [33:0] lim;
        lim = 34'(num_words) << 2;
        return (addr[1:0] != 2'b00) || ({2'b00, addr} >= lim);
    endfunction

endpackage

// File: rtl/proc_mem_responder_if.sv
// Request/response val/rdy bundle between a requester and the memory responder.
// The master drives requests and accepts responses; the slave does the reverse.
interface proc_mem_responder_if;

    logic        req_val;
    logic        req_rdy;
    logic        req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_val;
    logic        resp_rdy;
    logic        resp_type;
    logic [31:0] resp_data;
    logic        resp_err;

    modport master (
        output req_val, req_type, req_addr, req_wdata, resp_rdy,
        input  req_rdy, resp_val, resp_type, resp_data, resp_err
    );

    modport slave (
        input  req_val, req_type, req_addr, req_wdata, resp_rdy,
        output req_rdy, resp_val, resp_type, resp_data, resp_err
    );

endinterface

// File: rtl/proc_mem_resp_queue.sv
// Synchronous FIFO of response records with wrap-safe extra-bit pointers.
// An enqueue into a full queue is honoured when a dequeue happens on the same edge.
module proc_mem_resp_queue
    import proc_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      enq,
    input  mem_resp_t enq_data,
    input  logic      deq,
    output mem_resp_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    mem_resp_t   slot_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_enq;
    logic        do_deq;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_deq   = deq && !empty;
        do_enq   = enq && (!full || do_deq);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_enq};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_deq};
        head     = slot_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            slot_q[wr_ptr_q[AW-1:0]] <= enq_data;
        end
    end

endmodule

// File: rtl/proc_mem_responder.sv
// Fixed-latency memory responder: word storage, non-stalling delay pipeline,
// and a credit-admitted response queue so nothing in flight can be dropped.
module proc_mem_responder
    import proc_mem_pkg::*;
#(
    parameter int NUM_WORDS = 256,
    parameter int LATENCY   = 2,
    parameter int QDEPTH    = 4
) (
    input logic                 clk,
    input logic                 rst,
    proc_mem_responder_if.slave bus
);

    localparam int AW = $clog2(NUM_WORDS);
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(QDEPTH);

    logic [31:0]                mem_q [NUM_WORDS];
    logic [LATENCY-1:0]         vld_q, vld_d;
    mem_resp_t [LATENCY-1:0]    pipe_q, pipe_d;
    logic [CW-1:0]              credits_q, credits_d;

    logic      accept;
    logic      dequeue;
    logic      req_err;
    logic      req_rdy;
    logic      resp_val;
    logic      q_enq;
    logic      q_full;
    logic      q_empty;
    logic [AW-1:0] widx;
    mem_resp_t q_head;

    assign req_rdy  = rst && (credits_q != '0);
    assign resp_val = rst && !q_empty;

    assign bus.req_rdy   = req_rdy;
    assign bus.resp_val  = resp_val;
    assign bus.resp_type = resp_val ? q_head.typ : 1'b0;
    assign bus.resp_data = resp_val ? q_head.data : 32'h0;
    assign bus.resp_err  = resp_val ? q_head.err : 1'b0;

    always_comb begin
        req_err = addr_err(bus.req_addr, NUM_WORDS);
        widx    = bus.req_addr[AW+1:2];
        accept  = bus.req_val && req_rdy;
        dequeue = resp_val && bus.resp_rdy;
        q_enq   = vld_q[LATENCY-1] && (!q_full || dequeue);

        credits_d = credits_q
                  - {{(CW-1){1'b0}}, accept}
                  + {{(CW-1){1'b0}}, dequeue};

        vld_d  = '0;
        pipe_d = '0;
        // Read data is captured here, before this edge's write lands.
        vld_d[0]       = accept;
        pipe_d[0].typ  = bus.req_type;
        pipe_d[0].err  = req_err;
        pipe_d[0].data = (bus.req_type == MEM_WRITE || req_err)
                       ? 32'h0 : mem_q[widx];
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i]  = vld_q[i-1];
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q     <= '0;
            pipe_q    <= '0;
            credits_q <= CREDIT_MAX;
        end else begin
            vld_q     <= vld_d;
            pipe_q    <= pipe_d;
            credits_q <= credits_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && bus.req_type == MEM_WRITE && !req_err) begin
            mem_q[widx] <= bus.req_wdata;
        end
    end

    proc_mem_resp_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .enq      (q_enq),
        .enq_data (pipe_q[LATENCY-1]),
        .deq      (dequeue),
        .head     (q_head),
        .full     (q_full),
        .empty    (q_empty)
    );

endmodule

// File: tb/tb_proc_mem_responder.sv
// Bench for proc_mem_responder: vector table, hand sequences and random
// traffic checked against a queue-based transaction model.
module tb_proc_mem_responder;

    localparam int NW  = 256;
    localparam int LAT = 2;
    localparam int QD  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    proc_mem_responder_if bus ();

    proc_mem_responder #(
        .NUM_WORDS (NW),
        .LATENCY   (LAT),
        .QDEPTH    (QD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int unsigned acc_edge;
        logic        t;
        logic [31:0] d;
        logic        e;
    } pend_t;

    typedef struct {
        logic        v;
        logic        t;
        logic [31:0] a;
        logic [31:0] d;
        logic        rr;
        logic        x_rdy;
        logic        x_val;
        logic        x_t;
        logic [31:0] x_d;
        logic        x_e;
    } vec_t;

    pend_t       pend[$];
    logic [31:0] mem_m [NW];
    int unsigned edge_n = 0;
    bit          in_rst = 1'b1;
    int          n_vec = 0;
    int          n_err = 0;

    logic        o_rdy, o_val, o_t, o_e;
    logic [31:0] o_d;

    function automatic bit m_rdy();
        return !in_rst && (pend.size() < QD);
    endfunction

    function automatic bit m_val();
        if (in_rst || pend.size() == 0) return 1'b0;
        return edge_n >= pend[0].acc_edge + LAT;
    endfunction

    function automatic logic [31:0] init_val(input int i);
        return 32'h5A5A0000 ^ (32'(i) * 32'h00010001);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %h, expected %h",
                     nm, edge_n, act, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic t, input logic [31:0] a,
                         input logic [31:0] d, input logic rr);
        pend_t p;
        bit    acc, dq;
        @(negedge clk);
        o_rdy = bus.req_rdy;
        o_val = bus.resp_val;
        o_t   = bus.resp_type;
        o_d   = bus.resp_data;
        o_e   = bus.resp_err;
        chk("req_rdy", 32'(o_rdy), 32'(m_rdy()));
        chk("resp_val", 32'(o_val), 32'(m_val()));
        if (m_val()) begin
            chk("resp_type", 32'(o_t), 32'(pend[0].t));
            chk("resp_data", o_d, pend[0].d);
            chk("resp_err", 32'(o_e), 32'(pend[0].e));
        end else if (in_rst) begin
            chk("rst_type", 32'(o_t), 32'h0);
            chk("rst_data", o_d, 32'h0);
            chk("rst_err", 32'(o_e), 32'h0);
        end
        bus.req_val   = v;
        bus.req_type  = t;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.resp_rdy  = rr;
        acc = v && m_rdy();
        dq  = rr && m_val();
        @(posedge clk);
        edge_n++;
        if (dq) void'(pend.pop_front());
        if (acc) begin
            p.acc_edge = edge_n;
            p.t = t;
            p.e = (a[1:0] != 2'b00) || (a >= 32'(4 * NW));
            p.d = (t || p.e) ? 32'h0 : mem_m[a[9:2]];
            pend.push_back(p);
            if (t && !p.e) mem_m[a[9:2]] = d;
        end
    endtask

    task automatic idle(input logic rr);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, rr);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && pend.size() != 0; k++) idle(1'b1);
        idle(1'b1);
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b1;
        in_rst = 1'b0;
        @(posedge clk);
        edge_n++;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        bus.req_val = 1'b0;
        rst = 1'b0;
        in_rst = 1'b1;
        pend.delete();
        #1;
        chk("rst_now_val", 32'(bus.resp_val), 32'h0);
        chk("rst_now_rdy", 32'(bus.req_rdy), 32'h0);
        for (int k = 0; k < n; k++) idle(1'b0);
        release_rst();
    endtask

    vec_t tbl[14];
    int   acc_cnt;

    initial begin
        bus.req_val   = 1'b0;
        bus.req_type  = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.resp_rdy  = 1'b0;

        // Power-on reset held for three cycles.
        for (int k = 0; k < 3; k++) idle(1'b0);
        release_rst();
        idle(1'b1);

        for (int i = 0; i < NW; i++) cycle(1'b1, 1'b1, 32'(i) << 2, init_val(i), 1'b1);
        drain();

        tbl[0]  = '{1'b1, 1'b1, 32'h10,  32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 32'h402, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 32'h400, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 32'h400, 32'h11111111, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h5A5A0000, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0};
        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].v, tbl[i].t, tbl[i].a, tbl[i].d, tbl[i].rr);
            chk($sformatf("tbl%0d_rdy", i), 32'(o_rdy), 32'(tbl[i].x_rdy));
            chk($sformatf("tbl%0d_val", i), 32'(o_val), 32'(tbl[i].x_val));
            if (tbl[i].x_val) begin
                chk($sformatf("tbl%0d_type", i), 32'(o_t), 32'(tbl[i].x_t));
                chk($sformatf("tbl%0d_data", i), o_d, tbl[i].x_d);
                chk($sformatf("tbl%0d_err", i), 32'(o_e), 32'(tbl[i].x_e));
            end
        end
        drain();

        // Backpressure: six reads offered with the consumer stalled.
        acc_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, 32'(i + 20) << 2, 32'h0, 1'b0);
            if (o_rdy) acc_cnt++;
        end
        chk("bp_accepts", 32'(acc_cnt), 32'd4);
        for (int i = 0; i < 3; i++) idle(1'b0);
        drain();

        // Reset with requests in flight.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'(i) << 2, 32'h0, 1'b0);
        do_reset(2);
        for (int i = 0; i < 10; i++) idle(1'b1);
        acc_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 32'(i + 40) << 2, 32'h0, 1'b0);
            if (o_rdy) acc_cnt++;
        end
        chk("post_rst_accepts", 32'(acc_cnt), 32'd4);
        drain();

        // Accept and dequeue on the same edge with one credit left.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'(i + 60) << 2, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'd63 << 2, 32'h0, 1'b1);
        idle(1'b0);
        chk("one_credit_rdy", 32'(o_rdy), 32'h1);
        drain();

        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 9))
                0:       a = 32'($urandom_range(0, 1023));
                1:       a = 32'h400 + (32'($urandom_range(0, 255)) << 2);
                2:       a = 32'hFFFF_FFFC;
                default: a = 32'($urandom_range(0, NW - 1)) << 2;
            endcase
            if (i == 700) do_reset(1);
            cycle(($urandom % 4) != 0, 1'($urandom), a, $urandom,
                  (i % 100 < 70) ? (($urandom % 4) != 0) : 1'b0);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
